// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: launch FSM states and
// default word width / arm timeout.
package uart_pkg;
   localparam int UART_WIDTH       = 8;
   localparam int UART_ARM_TIMEOUT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      SEND = 2'd2
   } tx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty and a one-cycle overflow pulse.
// Optional macro UART_TXF_LEVEL_EN exposes the registered occupancy as level.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH  = UART_WIDTH,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
`ifdef UART_TXF_LEVEL_EN
   output logic [ADDR_W:0]  level,
`endif
   output logic             overflow
);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count, count_d;
   logic              push, pop;

   // Acceptance uses the registered full, so a pop on the same edge cannot
   // make room for a write that arrives while full.
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_d = count;
      if (push && !pop)      count_d = count + ONE_CNT;
      else if (pop && !push) count_d = count - ONE_CNT;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         count    <= count_d;
         full     <= (count_d == FULL_CNT);
         empty    <= (count_d == '0);
         overflow <= wr_en && full;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

`ifdef UART_TXF_LEVEL_EN
   assign level = count;
`endif
endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer plus launch FSM feeding the UART transmitter start/data/busy
// handshake. Optional macro UART_TXF_LEVEL_EN adds the occupancy output level.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH       = UART_WIDTH,
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = $clog2(DEPTH),
   parameter int ARM_TIMEOUT = UART_ARM_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic             empty,
   output logic             overflow,
`ifdef UART_TXF_LEVEL_EN
   output logic [ADDR_W:0]  level,
`endif
   input  logic             tx_busy,
   output logic             tx_start,
   output logic [WIDTH-1:0] tx_data
);
   localparam int TMR_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ARM_TIMEOUT - 1);

   tx_state_t        state, state_d;
   logic [TMR_W-1:0] timer, timer_d;
   logic             pop, start_d;
   logic [WIDTH-1:0] head;

   uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (head),
      .full     (full),
      .empty    (empty),
`ifdef UART_TXF_LEVEL_EN
      .level    (level),
`endif
      .overflow (overflow)
   );

   // The byte is popped at launch; a re-pulse in ARM reuses the held tx_data.
   always_comb begin
      state_d = state;
      timer_d = timer;
      pop     = 1'b0;
      start_d = 1'b0;
      case (state)
         IDLE: if (!empty && !tx_busy) begin
            pop     = 1'b1;
            start_d = 1'b1;
            timer_d = '0;
            state_d = ARM;
         end
         ARM: begin
            if (tx_busy) begin
               state_d = SEND;
               timer_d = '0;
            end else if (timer == TMR_LAST) begin
               start_d = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer + TMR_W'(1);
            end
         end
         SEND: if (!tx_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         timer    <= '0;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         state    <= state_d;
         timer    <= timer_d;
         tx_start <= start_d;
         if (pop) tx_data <= head;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter busy model.
// Compiles with or without UART_TXF_LEVEL_EN.
module tb_uart_tx_fifo;
   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full, empty, overflow;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
`ifdef UART_TXF_LEVEL_EN
   logic [4:0] level;
`endif

   logic auto_en, auto_busy, busy_manual;
   int   busy_len;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] rxq[$];
   logic [7:0] wq[$];

   assign tx_busy = auto_en ? auto_busy : busy_manual;

   always #5 clk = ~clk;

   uart_tx_fifo #(.WIDTH(8), .DEPTH(16), .ARM_TIMEOUT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .overflow (overflow),
`ifdef UART_TXF_LEVEL_EN
      .level    (level),
`endif
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Transmitter model: logs every launch, raises busy one cycle after a
   // start and holds it for busy_len cycles.
   initial begin
      logic pend, prev_start;
      int   bcnt;
      auto_busy  = 1'b0;
      pend       = 1'b0;
      prev_start = 1'b0;
      bcnt       = 0;
      forever begin
         tick();
         if (pend) begin
            auto_busy = 1'b1;
            bcnt      = busy_len;
            pend      = 1'b0;
         end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) auto_busy = 1'b0;
         end
         if (tx_start === 1'b1) begin
            check("start_not_consecutive", 32'(prev_start), 32'd0);
            rxq.push_back(tx_data);
            if (auto_en) pend = 1'b1;
         end
         prev_start = tx_start;
      end
   end

   initial begin
      logic push;
      int   sent, guard, refcnt;

      rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
      auto_en = 1'b0; busy_manual = 1'b0; busy_len = 10;

      // 1: reset
      tick(); tick(); tick();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      rst = 1'b1;
      tick();
      check("rel_empty", 32'(empty), 32'd1);
      check("rel_full", 32'(full), 32'd0);
      check("rel_overflow", 32'(overflow), 32'd0);
      check("rel_tx_start", 32'(tx_start), 32'd0);
      check("rel_tx_data", 32'(tx_data), 32'h00);

      // 2: single byte, launch latency and data hold
      auto_en = 1'b1;
      rxq.delete();
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      check("t2_empty_after_write", 32'(empty), 32'd0);
      check("t2_no_start_yet", 32'(tx_start), 32'd0);
      tick();
      check("t2_start", 32'(tx_start), 32'd1);
      check("t2_data", 32'(tx_data), 32'hA5);
      check("t2_empty_after_pop", 32'(empty), 32'd1);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("t2_start_low", 32'(tx_start), 32'd0);
         check("t2_data_hold", 32'(tx_data), 32'hA5);
      end
      for (int i = 0; i < 4; i++) tick();
      check("t2_launch_count", 32'(rxq.size()), 32'd1);

      // 3: fill to full, overflow, drain in order
      auto_en = 1'b0; busy_manual = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
         if (i == 14) check("t3_not_full_at_15", 32'(full), 32'd0);
      end
      wr_en = 1'b0;
      check("t3_full", 32'(full), 32'd1);
      check("t3_nonempty", 32'(empty), 32'd0);
      check("t3_no_overflow_yet", 32'(overflow), 32'd0);
      wr_en = 1'b1; wr_data = 8'hFF;
      tick();
      wr_en = 1'b0;
      check("t3_overflow_pulse", 32'(overflow), 32'd1);
      check("t3_still_full", 32'(full), 32'd1);
      tick();
      check("t3_overflow_clear", 32'(overflow), 32'd0);
      rxq.delete();
      auto_en = 1'b1;
      guard = 0;
      while (rxq.size() < 16 && guard < 800) begin tick(); guard++; end
      for (int i = 0; i < 16; i++) tick();
      check("t3_drain_count", 32'(rxq.size()), 32'd16);
      for (int i = 0; i < 16 && i < rxq.size(); i++)
         check($sformatf("t3_order_%0d", i), 32'(rxq[i]), 32'(i));
      check("t3_empty", 32'(empty), 32'd1);

      // 4: busy never rises, start re-pulses every 4 cycles
      auto_en = 1'b0; busy_manual = 1'b0;
      wr_en = 1'b1; wr_data = 8'h3C;
      tick();
      wr_en = 1'b0;
      tick();
      check("t4_first_start", 32'(tx_start), 32'd1);
      check("t4_first_data", 32'(tx_data), 32'h3C);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_gap_low", 32'(tx_start), 32'd0);
         end
         tick();
         check("t4_repulse", 32'(tx_start), 32'd1);
         check("t4_repulse_data", 32'(tx_data), 32'h3C);
         check("t4_no_extra_pop", 32'(empty), 32'd1);
      end
      busy_manual = 1'b1;
      tick();
      busy_manual = 1'b0;
      tick(); tick();

      // 5: asynchronous reset mid-SEND discards the queue
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      busy_manual = 1'b1;
      tick();
      check("t5_queued", 32'(empty), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("t5_async_empty", 32'(empty), 32'd1);
      check("t5_async_full", 32'(full), 32'd0);
      check("t5_async_overflow", 32'(overflow), 32'd0);
      check("t5_async_start", 32'(tx_start), 32'd0);
      check("t5_async_data", 32'(tx_data), 32'h00);
      tick(); tick();
      rst = 1'b1; busy_manual = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t5_no_launch", 32'(tx_start), 32'd0);
      end
      check("t5_empty_after", 32'(empty), 32'd1);

      // 6: random interleaved traffic across pointer wrap
      busy_len = 3; auto_en = 1'b1;
      rxq.delete(); wq.delete();
      sent = 0; guard = 0; refcnt = 0;
      while ((sent < 40 || rxq.size() < 40) && guard < 3000) begin
         if (sent < 40 && !full && $urandom_range(0, 2) != 0) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            wq.push_back(wr_data);
            sent++;
         end
         push = wr_en;
         tick();
         wr_en = 1'b0;
         if (push) refcnt++;
         if (tx_start) refcnt--;
`ifdef UART_TXF_LEVEL_EN
         check("t6_level", 32'(level), 32'(refcnt));
`endif
         guard++;
      end
      check("t6_rx_count", 32'(rxq.size()), 32'd40);
      for (int i = 0; i < 40 && i < rxq.size(); i++)
         check($sformatf("t6_order_%0d", i), 32'(rxq[i]), 32'(wq[i]));
      for (int i = 0; i < 8; i++) tick();
      check("t6_empty", 32'(empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
